fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, meaning PC value loaded by reset.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port PCSel, input, 3, next-PC select from control decode: 0 seq, 1 jump, 2 beq, 3 bne, 4 blt, 5 bge, 6/7 seq.
REQ-006 SHALL have ports BrEq and BrLT, input, 1 each, branch comparator results for the issued instruction.
REQ-007 SHALL have port ALUOut, input, 32, jump/branch target computed by datapath.
REQ-008 SHALL have port advance, input, 1, datapath pulse: issued instruction retires this cycle.
REQ-009 SHALL have ports imem_req (output, 1) and imem_addr (output, 32), instruction memory request and address.
REQ-010 SHALL have ports imem_valid (input, 1) and imem_rdata (input, 32), memory response strobe and data.
REQ-011 SHALL have ports instruction (output, 32), instValid (output, 1), pc (output, 32), pcPlus4 (output, 32), misalign (output, 1).

Function
REQ-012 SHALL implement states IDLE, FETCH, ISSUE, FAULT.
REQ-013 IDLE: outputs quiet; SHALL go to FETCH on the next cycle.
REQ-014 FETCH: imem_req=1, imem_addr=pc; on imem_valid=1, SHALL latch imem_rdata into instruction and go to ISSUE on the same edge.
REQ-015 ISSUE: instValid=1, imem_req=0; instruction and pc SHALL stay stable until advance=1.
REQ-016 On advance=1 in ISSUE, SHALL load pc with the selected next PC and go to FETCH; minimum advance-to-imem_req latency is 1 cycle.
REQ-017 Next PC: seq -> pc+4; jump -> {ALUOut[31:1],1'b0}; beq -> BrEq; bne -> !BrEq; blt -> BrLT; bge -> !BrLT; a taken branch SHALL use ALUOut and a not-taken branch SHALL use pc+4.
REQ-018 pcPlus4 SHALL equal pc+4 modulo 2^32; 32'hFFFF_FFFC SHALL wrap to 32'h0000_0000.
REQ-019 If the selected target has bit 1 set, SHALL leave pc unchanged, assert misalign, and go to FAULT.
REQ-020 FAULT: imem_req=0, instValid=0, misalign=1; SHALL be left only by rst.
REQ-021 imem_valid SHALL be ignored outside FETCH; advance SHALL be ignored outside ISSUE.
REQ-022 Multi-cycle memory latency SHALL be tolerated: FETCH holds imem_req and imem_addr stable until imem_valid.

Reset
REQ-023 On rst=1, SHALL set pc=RESET_VECTOR, instruction=32'h0000_0013 (nop), instValid=0, imem_req=0, misalign=0, state=IDLE.
REQ-024 rst SHALL take priority over every event, including imem_valid or advance in the same cycle.
REQ-025 Reset during FETCH SHALL abandon the outstanding request; memory SHALL NOT return data for the abandoned request after rst.

Structure
REQ-026 The shared package SHALL hold the PCSel encodings, the state enum, the nop constant and the RESET_VECTOR default.
REQ-027 Next-PC selection SHALL be one combinational sub-module, next_pc_sel, with inputs pc, PCSel, BrEq, BrLT and ALUOut, and outputs nextPc and misalign.

Verification
REQ-028 Reset then imem_valid after 3 wait cycles with rdata 32'h00500093 -> imem_addr=0 held for 4 cycles; instruction=32'h00500093, instValid=1, pc=0.
REQ-029 Sequential: advance with PCSel=0 at pc=0x10 -> next imem_addr=0x14, instValid=0 until the next imem_valid.
REQ-030 Branches at pc=0x20, ALUOut=0x40: beq with BrEq=1 -> 0x40; bne with BrEq=1 -> 0x24; blt with BrLT=0 -> 0x24; bge with BrLT=0 -> 0x40.
REQ-031 Jump with ALUOut=0x101 -> pc=0x100; jump with ALUOut=0x102 -> misalign=1, FAULT, imem_req stays 0 until rst.
REQ-032 Wrap and reset: seq at pc=0xFFFFFFFC -> pc=0; rst asserted in FETCH coincident with imem_valid -> pc=RESET_VECTOR, instValid=0, IDLE.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg
// Definitions shared by the instruction fetch unit and its next-PC selector:
//   - PCSel encodings produced by control decode
//   - fetch FSM state enumeration
//   - canonical nop instruction (addi x0, x0, 0)
//   - default reset vector
package fetch_unit_pkg;

    // PCSel encodings. Codes 6 and 7 are not assigned and behave as sequential.
    localparam logic [2:0] PCSEL_SEQ  = 3'd0;
    localparam logic [2:0] PCSEL_JUMP = 3'd1;
    localparam logic [2:0] PCSEL_BEQ  = 3'd2;
    localparam logic [2:0] PCSEL_BNE  = 3'd3;
    localparam logic [2:0] PCSEL_BLT  = 3'd4;
    localparam logic [2:0] PCSEL_BGE  = 3'd5;

    // Fetch FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_e;

    // addi x0, x0, 0 -- presented on the instruction port while nothing is issued.
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    // PC loaded by reset unless the instantiation overrides RESET_VECTOR.
    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

    // Sequential successor of a PC; wraps modulo 2^32.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc_in);
        return pc_in + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_unit_next_pc_sel.sv
// next_pc_sel
// Purely combinational next-PC selection.
// Ports:
//   pc       in  32  PC of the instruction currently issued
//   PCSel    in   3  next-PC select (seq / jump / beq / bne / blt / bge)
//   BrEq     in   1  branch comparator: operands equal
//   BrLT     in   1  branch comparator: rs1 less than rs2
//   ALUOut   in  32  jump / branch target from the datapath
//   nextPc   out 32  selected next PC
//   misalign out  1  selected target is not 4-byte aligned (bit 1 set)
module next_pc_sel
    import fetch_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [2:0]  PCSel,
    input  logic        BrEq,
    input  logic        BrLT,
    input  logic [31:0] ALUOut,
    output logic [31:0] nextPc,
    output logic        misalign
);

    logic [31:0] seq_pc;
    logic [31:0] jump_pc;
    logic        br_taken;

    always_comb begin
        seq_pc  = pc_plus4(pc);
        // Jump targets have bit 0 cleared, as the ISA requires for jalr.
        jump_pc = {ALUOut[31:1], 1'b0};

        br_taken = 1'b0;
        case (PCSel)
            PCSEL_BEQ: br_taken = BrEq;
            PCSEL_BNE: br_taken = !BrEq;
            PCSEL_BLT: br_taken = BrLT;
            PCSEL_BGE: br_taken = !BrLT;
            default:   br_taken = 1'b0;
        endcase

        nextPc = seq_pc;
        if (PCSel == PCSEL_JUMP) begin
            nextPc = jump_pc;
        end else if (br_taken) begin
            nextPc = ALUOut;
        end

        // Only bit 1 is considered: bit 0 is already cleared for jumps and
        // a misaligned halfword target is the fault condition of interest.
        misalign = nextPc[1];
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch unit: requests one instruction at a time from instruction
// memory, holds it for the datapath until it retires, then moves the PC to the
// selected successor. A misaligned target parks the unit in FAULT until reset.
// Ports:
//   clk          in   1  clock, rising edge
//   rst          in   1  synchronous active-high reset
//   PCSel        in   3  next-PC select from control decode
//   BrEq, BrLT   in   1  branch comparator results for the issued instruction
//   ALUOut       in  32  jump / branch target
//   advance      in   1  issued instruction retires this cycle
//   imem_req     out  1  instruction memory request
//   imem_addr    out 32  instruction memory address (current pc)
//   imem_valid   in   1  memory response strobe
//   imem_rdata   in  32  memory response data
//   instruction  out 32  issued instruction (nop while none fetched)
//   instValid    out  1  instruction holds a valid issued instruction
//   pc           out 32  PC of the issued / requested instruction
//   pcPlus4      out 32  pc + 4 (wraps)
//   misalign     out  1  sticky misaligned-target fault
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  PCSel,
    input  logic        BrEq,
    input  logic        BrLT,
    input  logic [31:0] ALUOut,
    input  logic        advance,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic        instValid,
    output logic [31:0] pc,
    output logic [31:0] pcPlus4,
    output logic        misalign
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic         inst_valid_q, inst_valid_d;
    logic         imem_req_q, imem_req_d;
    logic         misalign_q, misalign_d;

    logic [31:0]  sel_next_pc;
    logic         sel_misalign;

    next_pc_sel u_next_pc_sel (
        .pc       (pc_q),
        .PCSel    (PCSel),
        .BrEq     (BrEq),
        .BrLT     (BrLT),
        .ALUOut   (ALUOut),
        .nextPc   (sel_next_pc),
        .misalign (sel_misalign)
    );

    // Next-state logic. Outputs are registered, so each transition also
    // computes the output values that belong to the destination state.
    // imem_valid is only looked at in FETCH and advance only in ISSUE.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        inst_valid_d = inst_valid_q;
        imem_req_d   = imem_req_q;
        misalign_d   = misalign_q;

        case (state_q)
            ST_IDLE: begin
                state_d    = ST_FETCH;
                imem_req_d = 1'b1;
            end

            ST_FETCH: begin
                // Request and address stay put for as many cycles as memory needs.
                if (imem_valid) begin
                    instr_d      = imem_rdata;
                    inst_valid_d = 1'b1;
                    imem_req_d   = 1'b0;
                    state_d      = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                if (advance) begin
                    inst_valid_d = 1'b0;
                    if (sel_misalign) begin
                        // pc keeps the address of the faulting control transfer.
                        misalign_d = 1'b1;
                        state_d    = ST_FAULT;
                    end else begin
                        pc_d       = sel_next_pc;
                        imem_req_d = 1'b1;
                        state_d    = ST_FETCH;
                    end
                end
            end

            ST_FAULT: begin
                imem_req_d   = 1'b0;
                inst_valid_d = 1'b0;
                misalign_d   = 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Reset wins over any imem_valid or advance seen in the same cycle; an
    // outstanding request is simply dropped by returning to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_VECTOR;
            instr_q      <= INSTR_NOP;
            inst_valid_q <= 1'b0;
            imem_req_q   <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            inst_valid_q <= inst_valid_d;
            imem_req_q   <= imem_req_d;
            misalign_q   <= misalign_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign instruction = instr_q;
    assign instValid   = inst_valid_q;
    assign pc          = pc_q;
    assign pcPlus4     = pc_plus4(pc_q);
    assign misalign    = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [2:0]  PCSel;
    logic        BrEq;
    logic        BrLT;
    logic [31:0] ALUOut;
    logic        advance;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic        instValid;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic        misalign;

    int n_cmp = 0;
    int n_err = 0;

    fetch_unit #(.RESET_VECTOR(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .PCSel       (PCSel),
        .BrEq        (BrEq),
        .BrLT        (BrLT),
        .ALUOut      (ALUOut),
        .advance     (advance),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_rdata  (imem_rdata),
        .instruction (instruction),
        .instValid   (instValid),
        .pc          (pc),
        .pcPlus4     (pcPlus4),
        .misalign    (misalign)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock and sample 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Retire the issued instruction with the given control inputs, check the
    // new fetch request, then return it with zero wait cycles.
    task automatic step(input string tag, input logic [2:0] sel, input logic [31:0] alu,
                        input logic eq, input logic lt, input logic [31:0] exp_pc);
        PCSel   = sel;
        ALUOut  = alu;
        BrEq    = eq;
        BrLT    = lt;
        advance = 1'b1;
        tick();
        advance = 1'b0;
        check({tag, ".pc"}, pc, exp_pc);
        check({tag, ".addr"}, imem_addr, exp_pc);
        check({tag, ".req"}, {31'd0, imem_req}, 32'd1);
        check({tag, ".valid0"}, {31'd0, instValid}, 32'd0);
        imem_valid = 1'b1;
        imem_rdata = exp_pc ^ 32'h0000_0013;
        tick();
        imem_valid = 1'b0;
        check({tag, ".valid1"}, {31'd0, instValid}, 32'd1);
        check({tag, ".instr"}, instruction, exp_pc ^ 32'h0000_0013);
        $display("step %s: sel=%0d alu=%h eq=%0b lt=%0b -> pc=%h", tag, sel, alu, eq, lt, pc);
    endtask

    initial begin
        rst        = 1'b1;
        PCSel      = 3'd0;
        BrEq       = 1'b0;
        BrLT       = 1'b0;
        ALUOut     = 32'd0;
        advance    = 1'b0;
        imem_valid = 1'b0;
        imem_rdata = 32'd0;

        // Reset state
        tick();
        tick();
        check("rst.req", {31'd0, imem_req}, 32'd0);
        check("rst.valid", {31'd0, instValid}, 32'd0);
        check("rst.pc", pc, 32'h0000_0000);
        check("rst.instr", instruction, 32'h0000_0013);
        check("rst.misalign", {31'd0, misalign}, 32'd0);
        $display("reset: pc=%h instr=%h", pc, instruction);

        // IDLE -> FETCH, then 3 wait cycles with a stray advance (must be ignored)
        rst = 1'b0;
        tick();
        check("fetch0.req", {31'd0, imem_req}, 32'd1);
        check("fetch0.addr", imem_addr, 32'h0000_0000);
        PCSel   = 3'd1;
        ALUOut  = 32'h0000_0080;
        advance = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wait.req", {31'd0, imem_req}, 32'd1);
            check("wait.addr", imem_addr, 32'h0000_0000);
            check("wait.valid", {31'd0, instValid}, 32'd0);
        end
        advance    = 1'b0;
        imem_valid = 1'b1;
        imem_rdata = 32'h0050_0093;
        tick();
        imem_valid = 1'b0;
        check("first.instr", instruction, 32'h0050_0093);
        check("first.valid", {31'd0, instValid}, 32'd1);
        check("first.pc", pc, 32'h0000_0000);
        check("first.req", {31'd0, imem_req}, 32'd0);
        $display("first fetch: instr=%h pc=%h", instruction, pc);

        // ISSUE holds despite a stray imem_valid
        imem_valid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        tick();
        imem_valid = 1'b0;
        check("hold.instr", instruction, 32'h0050_0093);
        check("hold.valid", {31'd0, instValid}, 32'd1);
        check("hold.pc", pc, 32'h0000_0000);

        // Sequential from 0x10
        step("jmp10", 3'd1, 32'h0000_0010, 1'b0, 1'b0, 32'h0000_0010);
        check("jmp10.plus4", pcPlus4, 32'h0000_0014);
        step("seq",   3'd0, 32'h0000_0400, 1'b0, 1'b0, 32'h0000_0014);

        // Branches at pc=0x20 with ALUOut=0x40
        step("jmp20a", 3'd1, 32'h0000_0020, 1'b0, 1'b0, 32'h0000_0020);
        step("beq_t",  3'd2, 32'h0000_0040, 1'b1, 1'b0, 32'h0000_0040);
        step("jmp20b", 3'd1, 32'h0000_0020, 1'b0, 1'b0, 32'h0000_0020);
        step("bne_n",  3'd3, 32'h0000_0040, 1'b1, 1'b0, 32'h0000_0024);
        step("jmp20c", 3'd1, 32'h0000_0020, 1'b0, 1'b0, 32'h0000_0020);
        step("blt_n",  3'd4, 32'h0000_0040, 1'b0, 1'b0, 32'h0000_0024);
        step("jmp20d", 3'd1, 32'h0000_0020, 1'b0, 1'b0, 32'h0000_0020);
        step("bge_t",  3'd5, 32'h0000_0040, 1'b0, 1'b0, 32'h0000_0040);
        step("sel7",   3'd7, 32'h0000_0800, 1'b1, 1'b1, 32'h0000_0044);

        // Jump clears bit 0
        step("jmp101", 3'd1, 32'h0000_0101, 1'b0, 1'b0, 32'h0000_0100);

        // Wrap at the top of the address space
        step("jmptop", 3'd1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'hFFFF_FFFC);
        check("top.plus4", pcPlus4, 32'h0000_0000);
        step("wrap",   3'd0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000);

        // Reset in FETCH coincident with imem_valid
        PCSel   = 3'd0;
        advance = 1'b1;
        tick();
        advance = 1'b0;
        check("rf.pc_before", pc, 32'h0000_0004);
        rst        = 1'b1;
        imem_valid = 1'b1;
        imem_rdata = 32'h0000_0BAD;
        tick();
        rst        = 1'b0;
        imem_valid = 1'b0;
        check("rf.pc", pc, 32'h0000_0000);
        check("rf.valid", {31'd0, instValid}, 32'd0);
        check("rf.req", {31'd0, imem_req}, 32'd0);
        check("rf.instr", instruction, 32'h0000_0013);
        tick();
        check("rf.refetch_req", {31'd0, imem_req}, 32'd1);
        check("rf.refetch_addr", imem_addr, 32'h0000_0000);
        $display("reset in fetch: pc=%h instr=%h", pc, instruction);
        imem_valid = 1'b1;
        imem_rdata = 32'h0010_0113;
        tick();
        imem_valid = 1'b0;
        check("rf.issue_valid", {31'd0, instValid}, 32'd1);

        // Misaligned jump -> FAULT, sticky until reset
        PCSel   = 3'd1;
        ALUOut  = 32'h0000_0102;
        advance = 1'b1;
        tick();
        check("mis.flag", {31'd0, misalign}, 32'd1);
        check("mis.req", {31'd0, imem_req}, 32'd0);
        check("mis.valid", {31'd0, instValid}, 32'd0);
        check("mis.pc", pc, 32'h0000_0000);
        imem_valid = 1'b1;
        PCSel      = 3'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fault.flag", {31'd0, misalign}, 32'd1);
            check("fault.req", {31'd0, imem_req}, 32'd0);
            check("fault.pc", pc, 32'h0000_0000);
        end
        advance    = 1'b0;
        imem_valid = 1'b0;
        $display("fault: misalign=%0b pc=%h", misalign, pc);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("unfault.flag", {31'd0, misalign}, 32'd0);
        tick();
        check("unfault.req", {31'd0, imem_req}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
